// File: rtl/fft_ctrl_pkg.sv
// Shared constants, types and helpers for the FFT frame controller.
// Widths match the streaming FFT core sink/source buses.
package fft_ctrl_pkg;

  localparam int DW_IN       = 18;
  localparam int DW_OUT      = 29;
  localparam int AW          = 10;
  localparam int PTS_W       = 11;
  localparam int LOG2N_MIN   = 6;
  localparam int TIMEOUT_CYC = 4096;
  localparam int TMO_W       = 13;

  localparam int ERR_CORE  = 0;
  localparam int ERR_FRAME = 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    FIN
  } state_t;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [DW_IN-1:0] re;
    logic [DW_IN-1:0] im;
  } smp_t;

  function automatic logic cfg_ok(
    input logic [3:0] log2n
  );
    return (log2n >= 4'(LOG2N_MIN)) &&
           (log2n <= 4'(AW));
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry skid buffer between the sample RAM and the core sink.
// slot0 is always the head; slot1 only holds data when two are queued.
module fft_skid_buf
  import fft_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       fill_valid,
  input  smp_t       fill_data,
  input  logic       head_ready,
  output logic       head_valid,
  output smp_t       head_data,
  output logic [1:0] count
);

  smp_t       slot0;
  smp_t       slot1;
  logic [1:0] cnt;
  logic       pop;

  assign head_valid = (cnt != 2'd0);
  assign head_data  = slot0;
  assign count      = cnt;
  assign pop        = head_valid & head_ready;

  // Push/pop bookkeeping; the head never moves while it is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({fill_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= fill_data;
          else             slot1 <= fill_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= fill_data;
          end else begin
            slot0 <= slot1;
            slot1 <= fill_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: feeds N RAM samples into the FFT core and
// captures the core output into the result RAM with status.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            cfg_log2n,
  input  logic                  cfg_inverse,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  output logic [AW-1:0]         smp_rd_addr,
  input  logic [2*DW_IN-1:0]    smp_rd_data,
  output logic                  fft_sink_valid,
  input  logic                  fft_sink_ready,
  output logic                  fft_sink_sop,
  output logic                  fft_sink_eop,
  output logic [DW_IN-1:0]      fft_sink_real,
  output logic [DW_IN-1:0]      fft_sink_imag,
  output logic [1:0]            fft_sink_error,
  output logic [PTS_W-1:0]      fft_pts,
  output logic                  fft_inverse,
  input  logic                  fft_src_valid,
  output logic                  fft_src_ready,
  input  logic                  fft_src_sop,
  input  logic                  fft_src_eop,
  input  logic [DW_OUT-1:0]     fft_src_real,
  input  logic [DW_OUT-1:0]     fft_src_imag,
  input  logic [1:0]            fft_src_error,
  output logic                  res_wr_en,
  output logic [AW-1:0]         res_wr_addr,
  output logic [2*DW_OUT-1:0]   res_wr_data
);

  state_t           state;
  state_t           next;
  logic [PTS_W-1:0] pts;
  logic [PTS_W-1:0] pts_m1;
  logic [PTS_W-1:0] rd_cnt;
  logic [PTS_W-1:0] fl_idx;
  logic             inflight;
  logic [AW-1:0]    wr_cnt;
  logic             wr_done;
  logic [TMO_W-1:0] tmo;
  logic             bad_q;
  logic [1:0]       err_q;
  logic             inv_q;

  logic             in_feed;
  logic             in_live;
  logic             idle_go;
  logic             idle_bad;
  logic             rd_issue;
  logic             sink_beat;
  logic             src_beat;
  logic             wr_last;
  logic             frame_bad;
  logic             tmo_hit;

  logic             head_valid;
  smp_t             head_data;
  logic [1:0]       skid_cnt;
  smp_t             fill_data;

  assign in_feed  = (state == FEED);
  assign in_live  = (state == FEED) |
                    (state == DRAIN);
  assign idle_go  = (state == IDLE) & start &
                    cfg_ok(cfg_log2n);
  assign idle_bad = (state == IDLE) & start &
                    !cfg_ok(cfg_log2n);
  assign pts_m1   = pts - PTS_W'(1);

  assign rd_issue = in_feed & (rd_cnt < pts) &
                    ((skid_cnt + 2'(inflight)) < 2'd2);

  assign fill_data.sop = (fl_idx == '0);
  assign fill_data.eop = (fl_idx == pts_m1);
  assign fill_data.re  = smp_rd_data[2*DW_IN-1:DW_IN];
  assign fill_data.im  = smp_rd_data[DW_IN-1:0];

  fft_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .fill_valid (inflight),
    .fill_data  (fill_data),
    .head_ready (fft_sink_ready & in_feed),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (skid_cnt)
  );

  assign fft_sink_valid = head_valid & in_feed;
  assign sink_beat      = fft_sink_valid &
                          fft_sink_ready;
  assign fft_sink_sop   = fft_sink_valid &
                          head_data.sop;
  assign fft_sink_eop   = fft_sink_valid &
                          head_data.eop;
  assign fft_sink_real  = fft_sink_valid ?
                          head_data.re : '0;
  assign fft_sink_imag  = fft_sink_valid ?
                          head_data.im : '0;
  assign fft_sink_error = 2'b00;

  assign src_beat  = fft_src_valid & in_live;
  assign wr_last   = ({1'b0, wr_cnt} == pts_m1);
  assign frame_bad = src_beat &
                     ((fft_src_sop & (wr_cnt != '0)) |
                      (fft_src_eop & !wr_last) |
                      (!fft_src_sop & (wr_cnt == '0)));
  assign tmo_hit   = (state == DRAIN) & !src_beat &
                     (tmo == TMO_W'(TIMEOUT_CYC - 1));

  assign smp_rd_addr   = rd_cnt[AW-1:0];
  assign fft_src_ready = 1'b1;
  assign res_wr_en     = src_beat;
  assign res_wr_addr   = src_beat ? wr_cnt : '0;
  assign res_wr_data   = src_beat ?
                         {fft_src_real, fft_src_imag} : '0;

  assign busy        = in_live;
  assign done        = (state == FIN) | bad_q;
  assign err         = err_q;
  assign fft_pts     = pts;
  assign fft_inverse = inv_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Next-state decode.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (idle_go) next = FEED;
      FEED:  if (sink_beat & head_data.eop)
               next = DRAIN;
      DRAIN: if ((src_beat & wr_last) | wr_done |
                 tmo_hit)
               next = FIN;
      FIN:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Counters, frame config and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pts      <= '0;
      inv_q    <= 1'b0;
      rd_cnt   <= '0;
      fl_idx   <= '0;
      inflight <= 1'b0;
      wr_cnt   <= '0;
      wr_done  <= 1'b0;
      tmo      <= '0;
      bad_q    <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      inflight <= rd_issue;
      fl_idx   <= rd_cnt;
      bad_q    <= idle_bad;

      if (idle_go) begin
        pts     <= PTS_W'(1) << cfg_log2n;
        inv_q   <= cfg_inverse;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        wr_done <= 1'b0;
      end else begin
        if (rd_issue) rd_cnt <= rd_cnt + PTS_W'(1);
        if (src_beat) begin
          wr_cnt <= wr_last ? '0 : wr_cnt + AW'(1);
          if (wr_last) wr_done <= 1'b1;
        end
      end

      if ((state != DRAIN) | src_beat) tmo <= '0;
      else tmo <= tmo + TMO_W'(1);

      if (idle_go) begin
        err_q <= 2'b00;
      end else if (idle_bad) begin
        err_q <= 2'b10;
      end else begin
        if (src_beat & (fft_src_error != 2'b00))
          err_q[ERR_CORE] <= 1'b1;
        if (frame_bad | tmo_hit)
          err_q[ERR_FRAME] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with an echoing core model.
// Expected sink and result-write streams are queued and popped.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [3:0]          cfg_log2n = 4'd6;
  logic                cfg_inverse = 1'b0;
  logic                busy;
  logic                done;
  logic [1:0]          err;
  logic [AW-1:0]       smp_rd_addr;
  logic [2*DW_IN-1:0]  smp_rd_data = '0;
  logic                fft_sink_valid;
  logic                fft_sink_ready = 1'b1;
  logic                fft_sink_sop;
  logic                fft_sink_eop;
  logic [DW_IN-1:0]    fft_sink_real;
  logic [DW_IN-1:0]    fft_sink_imag;
  logic [1:0]          fft_sink_error;
  logic [PTS_W-1:0]    fft_pts;
  logic                fft_inverse;
  logic                fft_src_valid = 1'b0;
  logic                fft_src_ready;
  logic                fft_src_sop = 1'b0;
  logic                fft_src_eop = 1'b0;
  logic [DW_OUT-1:0]   fft_src_real = '0;
  logic [DW_OUT-1:0]   fft_src_imag = '0;
  logic [1:0]          fft_src_error = 2'b00;
  logic                res_wr_en;
  logic [AW-1:0]       res_wr_addr;
  logic [2*DW_OUT-1:0] res_wr_data;

  fft_frame_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_log2n      (cfg_log2n),
    .cfg_inverse    (cfg_inverse),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .smp_rd_addr    (smp_rd_addr),
    .smp_rd_data    (smp_rd_data),
    .fft_sink_valid (fft_sink_valid),
    .fft_sink_ready (fft_sink_ready),
    .fft_sink_sop   (fft_sink_sop),
    .fft_sink_eop   (fft_sink_eop),
    .fft_sink_real  (fft_sink_real),
    .fft_sink_imag  (fft_sink_imag),
    .fft_sink_error (fft_sink_error),
    .fft_pts        (fft_pts),
    .fft_inverse    (fft_inverse),
    .fft_src_valid  (fft_src_valid),
    .fft_src_ready  (fft_src_ready),
    .fft_src_sop    (fft_src_sop),
    .fft_src_eop    (fft_src_eop),
    .fft_src_real   (fft_src_real),
    .fft_src_imag   (fft_src_imag),
    .fft_src_error  (fft_src_error),
    .res_wr_en      (res_wr_en),
    .res_wr_addr    (res_wr_addr),
    .res_wr_data    (res_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]       a;
    logic [2*DW_OUT-1:0] d;
  } wr_t;

  logic [2*DW_IN-1:0] mem [1<<AW];
  smp_t exp_sink [$];
  smp_t core_q [$];
  wr_t  exp_wr [$];

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int n_pts = 64;
  int rdy_rand = 0;
  int echo_lim = 0;
  int echo_cnt = 0;
  int err_beat = -1;
  int out_idx = 0;
  int sink_beats = 0;
  int wr_n = 0;
  int done_cnt = 0;
  int last_sink_cyc = 0;
  int last_wr_cyc = 0;
  logic prev_stall = 1'b0;
  smp_t prev_smp = '0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [DW_OUT-1:0] sx(
    input logic [DW_IN-1:0] v
  );
    return {{(DW_OUT-DW_IN){v[DW_IN-1]}}, v};
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk) smp_rd_data <= mem[smp_rd_addr];

  always @(posedge clk) begin
    #1;
    fft_sink_ready = (rdy_rand != 0) ?
                     1'($urandom_range(0, 1)) : 1'b1;
  end

  // Core model: echoes accepted sink beats, sign-extended.
  always @(posedge clk) begin
    smp_t b;
    wr_t  w;
    #1;
    fft_src_valid = 1'b0;
    fft_src_sop   = 1'b0;
    fft_src_eop   = 1'b0;
    fft_src_error = 2'b00;
    if (reset) begin
      core_q.delete();
    end else if (core_q.size() != 0) begin
      b = core_q.pop_front();
      fft_src_valid = 1'b1;
      fft_src_sop   = b.sop;
      fft_src_eop   = b.eop;
      fft_src_real  = sx(b.re);
      fft_src_imag  = sx(b.im);
      if (out_idx == err_beat) fft_src_error = 2'b01;
      w.a = AW'(out_idx % n_pts);
      w.d = {sx(b.re), sx(b.im)};
      exp_wr.push_back(w);
      out_idx++;
    end
  end

  // Stream monitor: sink order/stability and result writes.
  always @(negedge clk) begin
    smp_t cur;
    smp_t e;
    wr_t  w;
    cur = {fft_sink_sop, fft_sink_eop,
           fft_sink_real, fft_sink_imag};
    if (prev_stall && !reset)
      chk("sink_hold", {fft_sink_valid, cur},
          {1'b1, prev_smp});
    prev_stall = fft_sink_valid & !fft_sink_ready;
    prev_smp   = cur;
    if (fft_sink_valid && fft_sink_ready) begin
      if (exp_sink.size() == 0) begin
        chk("sink_extra", 1, 0);
      end else begin
        e = exp_sink.pop_front();
        chk("sink_beat", cur, e);
      end
      sink_beats++;
      last_sink_cyc = cyc_n;
      if (echo_cnt < echo_lim) begin
        core_q.push_back(cur);
        echo_cnt++;
      end
    end
    if (res_wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("wr_extra", 1, 0);
      end else begin
        w = exp_wr.pop_front();
        chk("res_wr", {res_wr_addr, res_wr_data}, w);
      end
      wr_n++;
      last_wr_cyc = cyc_n;
    end
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ctl", {busy, done, err, fft_src_ready},
        5'b00001);
    chk("rst_sink", {fft_sink_valid, fft_sink_sop,
        fft_sink_eop, fft_sink_real, fft_sink_imag,
        fft_sink_error}, '0);
    chk("rst_cfg", {smp_rd_addr, fft_pts,
        fft_inverse}, '0);
    chk("rst_wr", {res_wr_en, res_wr_addr,
        res_wr_data}, '0);
  endtask

  task automatic begin_frame(input int log2n,
                             input logic inv,
                             input int rnd,
                             input int lim,
                             input int eb);
    n_pts = 1 << log2n;
    for (int i = 0; i < n_pts; i++) begin
      mem[i] = 36'({$urandom, $urandom});
      exp_sink.push_back({i == 0, i == n_pts - 1,
                          mem[i]});
    end
    out_idx    = 0;
    echo_cnt   = 0;
    echo_lim   = lim;
    err_beat   = eb;
    rdy_rand   = rnd;
    sink_beats = 0;
    wr_n       = 0;
    cfg_log2n   = 4'(log2n);
    cfg_inverse = inv;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
    chk("start_pts", fft_pts, n_pts);
    chk("start_inv", fft_inverse, inv);
  endtask

  task automatic end_frame(input int mode,
                           input logic [1:0] eerr,
                           input int ewr,
                           input int mid_start);
    int got;
    got = 0;
    for (int k = 0; k < 20000; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (k == mid_start) begin
        cfg_log2n = 4'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    if (mode == 0)
      chk("done_lat", cyc_n - last_wr_cyc, 1);
    else
      chk("tmo_lat", cyc_n - last_sink_cyc,
          TIMEOUT_CYC + 1);
    chk("done_err", err, eerr);
    chk("done_busy", busy, 0);
    chk("sink_count", sink_beats, n_pts);
    chk("sink_left", exp_sink.size(), 0);
    chk("wr_count", wr_n, ewr);
    chk("wr_left", exp_wr.size(), 0);
    cyc();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int d0;
    int lg [3];
    lg[0] = 3;
    lg[1] = 5;
    lg[2] = 11;

    reset = 1'b1;
    repeat (3) cyc();
    chk_reset_vals();
    reset = 1'b0;
    cyc();

    begin_frame(6, 1'b0, 0, 100000, -1);
    end_frame(0, 2'b00, 64, -1);

    begin_frame(10, 1'b1, 1, 100000, -1);
    end_frame(0, 2'b00, 1024, -1);
    rdy_rand = 0;

    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      sink_beats = 0;
      cfg_log2n = 4'(lg[i]);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("bad_done", done, 1);
      chk("bad_err", err, 2'b10);
      chk("bad_busy", busy, 0);
      cyc();
      chk("bad_pulse", {done, busy}, 2'b00);
      repeat (4) cyc();
      chk("bad_nobeat", sink_beats, 0);
      chk("bad_ndone", done_cnt - d0, 1);
    end

    begin_frame(6, 1'b0, 0, 40, -1);
    end_frame(1, 2'b10, 40, -1);

    begin_frame(6, 1'b0, 0, 100000, 5);
    end_frame(0, 2'b01, 64, 10);
    begin_frame(6, 1'b0, 0, 100000, -1);
    end_frame(0, 2'b00, 64, -1);

    begin_frame(8, 1'b0, 0, 100000, -1);
    for (int k = 0; k < 5000; k++) begin
      if (sink_beats >= 30) break;
      cyc();
    end
    chk("beat30", sink_beats, 30);
    d0 = done_cnt;
    reset = 1'b1;
    cyc();
    chk_reset_vals();
    cyc();
    reset = 1'b0;
    exp_sink.delete();
    exp_wr.delete();
    repeat (3) cyc();
    chk("rst_nodone", done_cnt - d0, 0);
    chk("rst_idle", busy, 0);
    begin_frame(8, 1'b1, 0, 100000, -1);
    end_frame(0, 2'b00, 256, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
